muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the single-cycle ALU in EX and takes ALU_OPERATION codes 01010..10001.
- Multiply: holds the product for a fixed latency. Divide/remainder: runs a 32-step restoring divider.
- Drives STALL to freeze the pipeline until DONE.

Parameters:
- MUL_LATENCY, 2: cycles from accept to DONE for multiply ops; legal range 1..8.
- WIDTH, 32: operand width; only 32 is supported.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request, qualified by ALU_OPERATION.
- ALU_OPERATION  input  5  op code; only 01010..10001 are accepted.
- DATA1  input  32  rs1 operand, sampled at accept.
- DATA2  input  32  rs2 operand, sampled at accept.
- FLUSH  input  1  aborts the operation in flight; no DONE is produced.
- STALL  output  1  combinational pipeline freeze.
- BUSY  output  1  registered; high while an operation is in flight.
- DONE  output  1  registered; one-cycle pulse with a valid RESULT.
- RESULT  output  32  registered; holds its value until the next DONE.

Behaviour:
- Clocking/reset: one clock CLK. RESET is synchronous and active-high. RESET wins over everything, including mid-operation. After reset: state=IDLE, BUSY=0, DONE=0, RESULT=0, counters=0.
- States: IDLE, MUL_WAIT, DIV_ITER, FINISH.
- Accept: in cycle N, state==IDLE and START=1 and op in 01010..10001 and FLUSH=0.
  - Operands and op are latched at the edge ending cycle N.
  - START with any other op is ignored: no accept, no stall.
  - START while not IDLE is ignored. The frozen pipeline holds START steady.
- STALL = (state!=IDLE) | (START & M-op & ~FLUSH).
  - State is IDLE in the DONE cycle, so STALL=0 there unless a new accept occurs.
  - Back-to-back accept in the DONE cycle is legal.
- BUSY = (state!=IDLE).
- Multiply path: the 64-bit product is formed at accept.
  - DATA1 signed for MULH and MULHSU. DATA2 signed for MULH only.
  - IDLE -> MUL_WAIT. A counter loads MUL_LATENCY-1 and decrements.
  - At 0: -> IDLE, DONE=1 in cycle N+MUL_LATENCY.
  - RESULT = low 32 bits for MUL, high 32 bits for the other three.
  - MUL_LATENCY=1: MUL_WAIT is skipped; IDLE -> IDLE with DONE in N+1.
- Divide special cases are resolved at accept; DONE in N+1 with no DIV_ITER.
  - DATA2==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give DATA1.
  - DIV with 0x80000000 / 0xFFFFFFFF gives 0x80000000. REM with the same operands gives 0.
- Divide normal path: latch |DATA1| and |DATA2| (raw values for DIVU/REMU) and record the quotient and remainder signs.
  - DIV_ITER runs exactly 32 cycles: one quotient bit per cycle via a 6-bit counter.
  - Then FINISH: sign fix-up. Quotient is negated if the operand signs differ (DIV only). Remainder takes the dividend's sign (REM only).
  - FINISH -> IDLE with DONE in cycle N+34.
- FLUSH:
  - Any non-IDLE state -> IDLE at the next edge.
  - DONE stays 0 and RESULT is unchanged.
  - FLUSH together with START is not accepted.
  - FLUSH in the DONE cycle has no effect on that DONE.
- DONE is never high for two consecutive cycles from one accept.

Decomposition:
- Shared package muldiv_pkg:
  - Op-code constants OP_MUL=5'b01010 through OP_REMU=5'b10001 (same values as the ALU case table).
  - State enum for IDLE/MUL_WAIT/DIV_ITER/FINISH.
  - DIV_STEPS=32.
- One sub-module, div_step: one combinational restoring-division step.
  - Inputs: partial remainder, quotient shift register, divisor.
  - Outputs: next remainder and next quotient.
- The sequencer registers div_step's outputs each DIV_ITER cycle.

Test Plan:
- MUL 7 x -3 (DATA2=0xFFFFFFFD), MUL_LATENCY=2 -> STALL high in cycles N..N+1; DONE only in N+2; RESULT=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> RESULT=0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> DONE at N+34, RESULT=0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF at N+1. REM 5 / 0 -> 5. DIV 0x80000000 / -1 -> 0x80000000. REM of the same -> 0.
- DIV started, FLUSH at N+10 -> IDLE at N+11, no DONE, RESULT unchanged. RESET at N+20 of a new DIV -> all outputs 0 next cycle.
- START held with op 00010 (ADD) -> no STALL, no DONE. DIVU accepted in the DONE cycle of a prior MUL -> second DONE at that cycle +34.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, state encoding and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

   localparam logic [4:0] OP_MUL    = 5'b01010;
   localparam logic [4:0] OP_MULH   = 5'b01011;
   localparam logic [4:0] OP_MULHSU = 5'b01100;
   localparam logic [4:0] OP_MULHU  = 5'b01101;
   localparam logic [4:0] OP_DIV    = 5'b01110;
   localparam logic [4:0] OP_DIVU   = 5'b01111;
   localparam logic [4:0] OP_REM    = 5'b10000;
   localparam logic [4:0] OP_REMU   = 5'b10001;

   localparam int DIV_STEPS = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL_WAIT,
      S_DIV_ITER,
      S_FINISH
   } state_e;

   function automatic logic is_mop(input logic [4:0] op);
      return (op >= OP_MUL) && (op <= OP_REMU);
   endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step (
   input  logic [31:0] rem_in,
   input  logic [31:0] quo_in,
   input  logic [31:0] divisor,
   output logic [31:0] rem_out,
   output logic [31:0] quo_out
);

   logic [32:0] shifted;
   logic [32:0] diff;
   logic        fits;

   always_comb begin
      // The dividend lives in the quotient register and is consumed MSB first.
      shifted = {rem_in, quo_in[31]};
      diff    = shifted - {1'b0, divisor};
      fits    = shifted >= {1'b0, divisor};
      rem_out = fits ? diff[31:0] : shifted[31:0];
      quo_out = {quo_in[30:0], fits};
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M controller: fixed-latency multiply, 32-step restoring divide,
// with a pipeline STALL held until the registered DONE pulse.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int MUL_LATENCY = 2,
   parameter int WIDTH       = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [4:0]       ALU_OPERATION,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   input  logic             FLUSH,
   output logic             STALL,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT
);

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [4:0]  op_q, op_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;
   logic [31:0] result_q, result_d;
   logic        done_q, done_d;

   logic        accept;
   logic        in_mul, in_sgn_div, in_is_div;
   logic [63:0] a_ext, b_ext, prod;
   logic [31:0] mul_res, a_abs, b_abs;
   logic [31:0] step_rem, step_quo;

   div_step u_div_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (dvs_q),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   always_comb begin
      accept     = (state_q == S_IDLE) & START & is_mop(ALU_OPERATION) & ~FLUSH;
      in_mul     = ALU_OPERATION <= OP_MULHU;
      in_sgn_div = (ALU_OPERATION == OP_DIV) | (ALU_OPERATION == OP_REM);
      in_is_div  = (ALU_OPERATION == OP_DIV) | (ALU_OPERATION == OP_DIVU);
      // Truncated two's-complement product is sign-agnostic once operands are extended.
      a_ext   = {{32{((ALU_OPERATION == OP_MULH) | (ALU_OPERATION == OP_MULHSU)) & DATA1[31]}}, DATA1};
      b_ext   = {{32{(ALU_OPERATION == OP_MULH) & DATA2[31]}}, DATA2};
      prod    = a_ext * b_ext;
      mul_res = (ALU_OPERATION == OP_MUL) ? prod[31:0] : prod[63:32];
      a_abs   = (in_sgn_div & DATA1[31]) ? -DATA1 : DATA1;
      b_abs   = (in_sgn_div & DATA2[31]) ? -DATA2 : DATA2;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      result_d = result_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d = ALU_OPERATION;
               if (in_mul) begin
                  if (MUL_LATENCY == 1) begin
                     result_d = mul_res;
                     done_d   = 1'b1;
                  end else begin
                     quo_d   = mul_res;
                     cnt_d   = 6'(MUL_LATENCY - 1);
                     state_d = S_MUL_WAIT;
                  end
               end else if (DATA2 == 32'd0) begin
                  result_d = in_is_div ? 32'hFFFF_FFFF : DATA1;
                  done_d   = 1'b1;
               end else if (in_sgn_div && DATA1 == 32'h8000_0000 && DATA2 == 32'hFFFF_FFFF) begin
                  result_d = in_is_div ? 32'h8000_0000 : 32'd0;
                  done_d   = 1'b1;
               end else begin
                  rem_d   = 32'd0;
                  quo_d   = a_abs;
                  dvs_d   = b_abs;
                  q_neg_d = in_sgn_div & (DATA1[31] ^ DATA2[31]);
                  r_neg_d = in_sgn_div & DATA1[31];
                  cnt_d   = 6'd0;
                  state_d = S_DIV_ITER;
               end
            end
         end
         S_MUL_WAIT: begin
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               result_d = quo_q;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
         S_DIV_ITER: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(DIV_STEPS - 1)) state_d = S_FINISH;
         end
         S_FINISH: begin
            if ((op_q == OP_DIV) || (op_q == OP_DIVU))
               result_d = q_neg_q ? -quo_q : quo_q;
            else
               result_d = r_neg_q ? -rem_q : rem_q;
            done_d  = 1'b1;
            cnt_d   = 6'd0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort drops the operation without touching RESULT.
      if (FLUSH && state_q != S_IDLE) begin
         state_d  = S_IDLE;
         cnt_d    = 6'd0;
         result_d = result_q;
         done_d   = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= 6'd0;
         op_q     <= 5'd0;
         rem_q    <= 32'd0;
         quo_q    <= 32'd0;
         dvs_q    <= 32'd0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign STALL  = (state_q != S_IDLE) | (START & is_mop(ALU_OPERATION) & ~FLUSH);
   assign BUSY   = state_q != S_IDLE;
   assign DONE   = done_q;
   assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector bench for muldiv_sequencer: result values, DONE latency, STALL/FLUSH/RESET corners.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET, START, FLUSH;
   logic [4:0]  ALU_OPERATION;
   logic [31:0] DATA1, DATA2;
   logic        STALL, BUSY, DONE;
   logic [31:0] RESULT;

   int total = 0;
   int bad   = 0;

   muldiv_sequencer #(.MUL_LATENCY(2), .WIDTH(32)) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .START         (START),
      .ALU_OPERATION (ALU_OPERATION),
      .DATA1         (DATA1),
      .DATA2         (DATA2),
      .FLUSH         (FLUSH),
      .STALL         (STALL),
      .BUSY          (BUSY),
      .DONE          (DONE),
      .RESULT        (RESULT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Issue one op in the current idle cycle N, then measure DONE latency and RESULT.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat);
      int  k;
      bit  got, stall_ok;
      @(negedge CLK);
      START = 1'b1; ALU_OPERATION = op; DATA1 = a; DATA2 = b;
      #1 chk({tag, " stall_at_accept"}, 32'(STALL), 32'd1);
      @(posedge CLK);
      #1 START = 1'b0;
      k = 0; got = 0; stall_ok = 1;
      while (k < 60 && !got) begin
         @(negedge CLK);
         k++;
         if (DONE) got = 1;
         else if (!STALL) stall_ok = 0;
      end
      chk({tag, " done_seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, 32'(k), 32'(lat));
      chk({tag, " result"}, RESULT, res);
      chk({tag, " stall_held"}, 32'(stall_ok), 32'd1);
      chk({tag, " stall_in_done"}, 32'(STALL), 32'd0);
      @(negedge CLK);
      chk({tag, " done_single"}, 32'(DONE), 32'd0);
   endtask

   initial begin
      int  k;
      bit  flag;
      logic [31:0] last_res;

      vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
      vecs[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2};
      vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
      vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 2};
      vecs[4]  = '{OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         2};
      vecs[5]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
      vecs[6]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
      vecs[7]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14,        34};
      vecs[8]  = '{OP_REMU,   32'd100,        32'd7,         32'd2,         34};
      vecs[9]  = '{OP_DIV,    32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 34};
      vecs[10] = '{OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
      vecs[11] = '{OP_REM,    32'd5,          32'd0,         32'd5,         1};
      vecs[12] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[13] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

      RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
      ALU_OPERATION = 5'd0; DATA1 = 32'd0; DATA2 = 32'd0;
      repeat (3) @(negedge CLK);
      chk("reset busy", 32'(BUSY), 32'd0);
      chk("reset done", 32'(DONE), 32'd0);
      chk("reset result", RESULT, 32'd0);
      chk("reset stall", 32'(STALL), 32'd0);
      RESET = 1'b0;

      for (int i = 0; i < 14; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
      last_res = vecs[13].res;

      // ADD with START held: not an M-op, so nothing happens.
      @(negedge CLK);
      START = 1'b1; ALU_OPERATION = 5'b00010; DATA1 = 32'd3; DATA2 = 32'd4;
      flag = 1;
      for (int i = 0; i < 5; i++) begin
         #1 if (STALL || BUSY || DONE) flag = 0;
         @(negedge CLK);
      end
      chk("add ignored", 32'(flag), 32'd1);
      START = 1'b0;

      // FLUSH together with START blocks the accept.
      START = 1'b1; FLUSH = 1'b1; ALU_OPERATION = OP_MUL;
      #1 chk("flush_start stall", 32'(STALL), 32'd0);
      @(negedge CLK);
      START = 1'b0; FLUSH = 1'b0;
      chk("flush_start busy", 32'(BUSY), 32'd0);

      // FLUSH in cycle N+10 of a DIV.
      @(negedge CLK);
      START = 1'b1; ALU_OPERATION = OP_DIV; DATA1 = 32'd100; DATA2 = 32'd7;
      @(posedge CLK);
      #1 START = 1'b0;
      for (k = 1; k <= 10; k++) @(negedge CLK);
      FLUSH = 1'b1;
      @(negedge CLK);
      FLUSH = 1'b0;
      chk("flush busy", 32'(BUSY), 32'd0);
      chk("flush stall", 32'(STALL), 32'd0);
      flag = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (DONE) flag = 1;
      end
      chk("flush no_done", 32'(flag), 32'd0);
      chk("flush result_kept", RESULT, last_res);

      // RESET in cycle N+20 of a DIV.
      @(negedge CLK);
      START = 1'b1; ALU_OPERATION = OP_DIVU; DATA1 = 32'd1000; DATA2 = 32'd3;
      @(posedge CLK);
      #1 START = 1'b0;
      for (k = 1; k <= 20; k++) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      chk("midreset busy", 32'(BUSY), 32'd0);
      chk("midreset done", 32'(DONE), 32'd0);
      chk("midreset result", RESULT, 32'd0);
      chk("midreset stall", 32'(STALL), 32'd0);
      RESET = 1'b0;

      // DIVU accepted in the DONE cycle of a MUL.
      @(negedge CLK);
      START = 1'b1; ALU_OPERATION = OP_MUL; DATA1 = 32'd7; DATA2 = 32'hFFFF_FFFD;
      @(posedge CLK);
      #1 START = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("b2b mul_done", 32'(DONE), 32'd1);
      chk("b2b mul_result", RESULT, 32'hFFFF_FFEB);
      START = 1'b1; ALU_OPERATION = OP_DIVU; DATA1 = 32'd100; DATA2 = 32'd7;
      #1 chk("b2b stall", 32'(STALL), 32'd1);
      @(posedge CLK);
      #1 START = 1'b0;
      k = 0; flag = 0;
      while (k < 60 && !flag) begin
         @(negedge CLK);
         k++;
         if (DONE) flag = 1;
      end
      chk("b2b div_done", 32'(flag), 32'd1);
      chk("b2b div_latency", 32'(k), 32'd34);
      chk("b2b div_result", RESULT, 32'd14);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
